// File: rtl/power_scan_pkg.sv
// power_scan_pkg: shared constants, sample vector type and scan state encoding
// for the power_scan_ctrl direction scanner.
package power_scan_pkg;

  localparam int N_CH   = 12;
  localparam int DATA_W = 24;
  localparam int RES_W  = 64;

  typedef logic signed [DATA_W-1:0] sample_t;
  typedef sample_t [N_CH-1:0]       sample_vec_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    COMPARE,
    DONE,
    FLUSH
  } scan_state_e;

  // Index width that never collapses to zero bits when only one value exists.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/power_scan_ctrl_if.sv
// power_scan_ctrl_if: beam-buffer read port plus the Square_Add stream port
// of the scanner; master = power_scan_ctrl, slave = buffer/Square_Add side.
interface power_scan_ctrl_if
  import power_scan_pkg::*;
#(
  parameter int N_DIR     = 8,
  parameter int N_SAMPLES = 64
);

  localparam int DIR_W = idx_w(N_DIR);
  localparam int IDX_W = idx_w(N_SAMPLES);

  logic                    o_rd_en;
  logic [DIR_W-1:0]        o_rd_dir;
  logic [IDX_W-1:0]        o_rd_idx;
  sample_vec_t             i_rd_data;
  logic                    o_sq_valid;
  sample_vec_t             o_sq_data;
  logic signed [RES_W-1:0] i_sq_result;
  logic                    i_sq_ready;

  modport master (
    output o_rd_en, o_rd_dir, o_rd_idx, o_sq_valid, o_sq_data,
    input  i_rd_data, i_sq_result, i_sq_ready
  );

  modport slave (
    input  o_rd_en, o_rd_dir, o_rd_idx, o_sq_valid, o_sq_data,
    output i_rd_data, i_sq_result, i_sq_ready
  );

endinterface

// File: rtl/power_argmax.sv
// power_argmax: running maximum of per-direction energies; ties keep the
// earlier (lower) direction because only a strictly larger energy replaces it.
module power_argmax
  import power_scan_pkg::*;
#(
  parameter int DIR_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             first,
  input  logic             compare,
  input  logic [DIR_W-1:0] dir,
  input  logic [RES_W-1:0] energy,
  output logic [DIR_W-1:0] best_dir,
  output logic [RES_W-1:0] best_energy
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_dir    <= '0;
      best_energy <= '0;
    end else if (clear) begin
      best_dir    <= '0;
      best_energy <= '0;
    end else if (compare && (first || (energy > best_energy))) begin
      best_dir    <= dir;
      best_energy <= energy;
    end
  end

endmodule

// File: rtl/power_scan_ctrl.sv
// power_scan_ctrl: time-shares one external Square_Add unit across N_DIR steering
// directions and reports the max-energy one. Define POWER_SCAN_SAT_EN to saturate the accumulator.
module power_scan_ctrl
  import power_scan_pkg::*;
#(
  parameter int N_DIR     = 8,
  parameter int N_SAMPLES = 64
) (
  input  logic                    i_50M_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic                    i_abort,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [idx_w(N_DIR)-1:0] o_best_dir,
  output logic [RES_W-1:0]        o_best_energy,
  power_scan_ctrl_if.master       bus
);

  localparam int DIR_W = idx_w(N_DIR);
  localparam int IDX_W = idx_w(N_SAMPLES);
  localparam int CNT_W = idx_w(N_SAMPLES + 1);

  localparam logic [DIR_W-1:0] LAST_DIR = DIR_W'(N_DIR - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SAMPLES - 1);
  localparam logic [CNT_W-1:0] ALL_RCVD = CNT_W'(N_SAMPLES);

  scan_state_e      state;
  logic [DIR_W-1:0] dir;
  logic [IDX_W-1:0] idx;
  logic             rd_en;
  logic             sq_valid;
  logic [RES_W-1:0] acc;
  logic [CNT_W-1:0] rcv_cnt;
  logic [CNT_W-1:0] outstanding;
  logic [DIR_W-1:0] best_dir;
  logic [RES_W-1:0] best_energy;
  logic             accepted_start;
  logic             argmax_cmp;
  logic             result_in;

  // Energies are nonnegative, so the sum is treated as unsigned.
  function automatic logic [RES_W-1:0] acc_add(input logic [RES_W-1:0] a,
                                               input logic [RES_W-1:0] b);
`ifdef POWER_SCAN_SAT_EN
    logic [RES_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[RES_W] ? '1 : sum[RES_W-1:0];
`else
    return a + b;
`endif
  endfunction

  assign bus.o_rd_en    = rd_en;
  assign bus.o_rd_dir   = dir;
  assign bus.o_rd_idx   = idx;
  assign bus.o_sq_valid = sq_valid;
  assign bus.o_sq_data  = bus.i_rd_data;

  assign accepted_start = (state == IDLE) && i_start;
  assign argmax_cmp     = (state == COMPARE) && !i_abort;
  assign result_in      = bus.i_sq_ready && (state != FLUSH);

  power_argmax #(
    .DIR_W (DIR_W)
  ) u_argmax (
    .clk         (i_50M_clk),
    .rst_n       (i_rst_n),
    .clear       (accepted_start),
    .first       (dir == '0),
    .compare     (argmax_cmp),
    .dir         (dir),
    .energy      (acc),
    .best_dir    (best_dir),
    .best_energy (best_energy)
  );

  // Results in flight inside Square_Add, independent of its latency.
  always_ff @(posedge i_50M_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sq_valid    <= 1'b0;
      outstanding <= '0;
    end else begin
      sq_valid <= rd_en;
      case ({sq_valid, bus.i_sq_ready})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  always_ff @(posedge i_50M_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      dir           <= '0;
      idx           <= '0;
      rd_en         <= 1'b0;
      acc           <= '0;
      rcv_cnt       <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_best_dir    <= '0;
      o_best_energy <= '0;
    end else begin
      o_done <= 1'b0;
      if (result_in) begin
        acc     <= acc_add(acc, bus.i_sq_result);
        rcv_cnt <= rcv_cnt + CNT_W'(1);
      end
      case (state)
        IDLE: begin
          if (i_start) begin
            state   <= ISSUE;
            dir     <= '0;
            idx     <= '0;
            acc     <= '0;
            rcv_cnt <= '0;
            rd_en   <= 1'b1;
            o_busy  <= 1'b1;
          end
        end
        ISSUE: begin
          if (i_abort) begin
            state <= FLUSH;
            rd_en <= 1'b0;
          end else if (idx == LAST_IDX) begin
            state <= DRAIN;
            rd_en <= 1'b0;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        DRAIN: begin
          if (i_abort) begin
            state <= FLUSH;
          end else if ((outstanding == '0) && (rcv_cnt == ALL_RCVD)) begin
            state <= COMPARE;
          end
        end
        COMPARE: begin
          if (i_abort) begin
            state <= FLUSH;
          end else if (dir == LAST_DIR) begin
            state <= DONE;
          end else begin
            state   <= ISSUE;
            dir     <= dir + DIR_W'(1);
            idx     <= '0;
            acc     <= '0;
            rcv_cnt <= '0;
            rd_en   <= 1'b1;
          end
        end
        DONE: begin
          o_best_dir    <= best_dir;
          o_best_energy <= best_energy;
          o_done        <= 1'b1;
          o_busy        <= 1'b0;
          state         <= IDLE;
        end
        FLUSH: begin
          // The read issued in the abort cycle shows up as sq_valid one cycle later.
          if ((outstanding == '0) && !sq_valid) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_power_scan_ctrl.sv
// tb_power_scan_ctrl: directed scoreboard bench for power_scan_ctrl with a
// behavioural beam buffer, a 2-cycle Square_Add model and a saturation stub.
module tb_power_scan_ctrl;
  import power_scan_pkg::*;

  localparam int N_DIR     = 4;
  localparam int N_SAMPLES = 4;

`ifdef POWER_SCAN_SAT_EN
  localparam logic [RES_W-1:0] SAT_EXP = '1;
`else
  localparam logic [RES_W-1:0] SAT_EXP = '0;
`endif

  typedef struct packed {
    logic [1:0]       dir;
    logic [RES_W-1:0] energy;
  } exp_t;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             start     = 1'b0;
  logic             abort     = 1'b0;
  logic             sat_start = 1'b0;
  logic             busy, done, sat_busy, sat_done;
  logic [1:0]       best_dir;
  logic [0:0]       sat_best_dir;
  logic [RES_W-1:0] best_energy, sat_best_energy;
  bit               fill_mode = 1'b0;
  int               vectors = 0;
  int               miscompares = 0;
  int               rd_count = 0;
  int               done_count = 0;
  int               sat_done_count = 0;
  exp_t             exp_q[$];
  logic [RES_W-1:0] sat_q[$];
  logic             sq_v1;
  logic [RES_W-1:0] sq_s1;

  always #5 clk = ~clk;

  power_scan_ctrl_if #(.N_DIR(N_DIR), .N_SAMPLES(N_SAMPLES)) bus ();
  power_scan_ctrl_if #(.N_DIR(1), .N_SAMPLES(2)) sat_bus ();

  power_scan_ctrl #(.N_DIR(N_DIR), .N_SAMPLES(N_SAMPLES)) dut (
    .i_50M_clk     (clk),
    .i_rst_n       (rst_n),
    .i_start       (start),
    .i_abort       (abort),
    .o_busy        (busy),
    .o_done        (done),
    .o_best_dir    (best_dir),
    .o_best_energy (best_energy),
    .bus           (bus)
  );

  power_scan_ctrl #(.N_DIR(1), .N_SAMPLES(2)) sat_dut (
    .i_50M_clk     (clk),
    .i_rst_n       (rst_n),
    .i_start       (sat_start),
    .i_abort       (1'b0),
    .o_busy        (sat_busy),
    .o_done        (sat_done),
    .o_best_dir    (sat_best_dir),
    .o_best_energy (sat_best_energy),
    .bus           (sat_bus)
  );

  function automatic sample_vec_t fill_vec(input int v);
    sample_vec_t r;
    for (int c = 0; c < N_CH; c++) r[c] = sample_t'(v);
    return r;
  endfunction

  function automatic logic [RES_W-1:0] sum_sq(input sample_vec_t v);
    longint s;
    longint t;
    s = 0;
    for (int c = 0; c < N_CH; c++) begin
      t = longint'(v[c]);
      s += t * t;
    end
    return s;
  endfunction

  // Beam buffer: all channels carry dir+1, or 2 in the tie pattern.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.i_rd_data <= '0;
    else if (bus.o_rd_en)
      bus.i_rd_data <= fill_vec(fill_mode ? 2 : int'(bus.o_rd_dir) + 1);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_v1           <= 1'b0;
      sq_s1           <= '0;
      bus.i_sq_ready  <= 1'b0;
      bus.i_sq_result <= '0;
    end else begin
      sq_v1           <= bus.o_sq_valid;
      sq_s1           <= sum_sq(bus.o_sq_data);
      bus.i_sq_ready  <= sq_v1;
      bus.i_sq_result <= sq_s1;
    end
  end

  assign sat_bus.i_rd_data = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_bus.i_sq_ready  <= 1'b0;
      sat_bus.i_sq_result <= '0;
    end else begin
      sat_bus.i_sq_ready  <= sat_bus.o_sq_valid;
      sat_bus.i_sq_result <= 64'h8000_0000_0000_0000;
    end
  end

  task automatic checkOutput(input string name, input logic [RES_W-1:0] actual,
                             input logic [RES_W-1:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  // Scoreboard monitors: pop one expectation per o_done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (bus.o_rd_en) rd_count++;
    if (done) begin
      done_count++;
      if (exp_q.size() == 0) checkOutput("done_pending", 64'(done), 0);
      else begin
        e = exp_q.pop_front();
        checkOutput("best_dir", 64'(best_dir), 64'(e.dir));
        checkOutput("best_energy", best_energy, e.energy);
      end
    end
  end

  always @(negedge clk) begin
    logic [RES_W-1:0] se;
    if (sat_done) begin
      sat_done_count++;
      if (sat_q.size() == 0) checkOutput("sat_done_pending", 64'(sat_done), 0);
      else begin
        se = sat_q.pop_front();
        checkOutput("sat_best_dir", 64'(sat_best_dir), 0);
        checkOutput("sat_best_energy", sat_best_energy, se);
      end
    end
  end

  task automatic applyStimulus(input bit mode, input bit expect_done,
                               input logic [1:0] exp_dir, input logic [RES_W-1:0] exp_energy);
    exp_t e;
    fill_mode = mode;
    if (expect_done) begin
      e.dir    = exp_dir;
      e.energy = exp_energy;
      exp_q.push_back(e);
    end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 64'(busy), 0);
    @(negedge clk);
  endtask

  task automatic waitRead(input int d, input int i, input string name);
    int n;
    n = 0;
    while (!(bus.o_rd_en && bus.o_rd_dir == 2'(d) && bus.o_rd_idx == 2'(i)) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 64'(n < 200), 1);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_busy"}, 64'(busy), 0);
    checkOutput({tag, "_done"}, 64'(done), 0);
    checkOutput({tag, "_best_dir"}, 64'(best_dir), 0);
    checkOutput({tag, "_best_energy"}, best_energy, 0);
    checkOutput({tag, "_rd_en"}, 64'(bus.o_rd_en), 0);
    checkOutput({tag, "_rd_dir"}, 64'(bus.o_rd_dir), 0);
    checkOutput({tag, "_rd_idx"}, 64'(bus.o_rd_idx), 0);
    checkOutput({tag, "_sq_valid"}, 64'(bus.o_sq_valid), 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int rd_base;
    int done_base;
    int sat_base;

    repeat (3) @(negedge clk);
    checkAllZero("rst");
    checkOutput("rst_sq_data", 64'(bus.o_sq_data[0]), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Ramp pattern: energies 48/192/432/768, direction 3 wins.
    rd_base = rd_count;
    done_base = done_count;
    applyStimulus(1'b0, 1'b1, 2'd3, 768);
    checkOutput("busy_rise", 64'(busy), 1);
    checkOutput("first_rd_en", 64'(bus.o_rd_en), 1);
    checkOutput("first_rd_dir", 64'(bus.o_rd_dir), 0);
    checkOutput("first_rd_idx", 64'(bus.o_rd_idx), 0);
    @(negedge clk);
    checkOutput("first_sq_valid", 64'(bus.o_sq_valid), 1);
    checkOutput("sq_data_ch0", 64'(bus.o_sq_data[0]), 1);
    checkOutput("rd_idx_step", 64'(bus.o_rd_idx), 1);
    waitIdle("scan1_idle");
    checkOutput("scan1_reads", 64'(rd_count - rd_base), 16);
    checkOutput("scan1_dones", 64'(done_count - done_base), 1);

    // Tie pattern with a stray start during ISSUE: direction 0 must win.
    rd_base = rd_count;
    done_base = done_count;
    applyStimulus(1'b1, 1'b1, 2'd0, 192);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitIdle("scan2_idle");
    checkOutput("scan2_reads", 64'(rd_count - rd_base), 16);
    checkOutput("scan2_dones", 64'(done_count - done_base), 1);
    repeat (5) @(negedge clk);
    checkOutput("no_restart", 64'(busy), 0);

    // Abort on the third read of direction 1.
    rd_base = rd_count;
    done_base = done_count;
    applyStimulus(1'b0, 1'b0, 2'd0, 0);
    waitRead(1, 2, "abort_point");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_rd_stop", 64'(bus.o_rd_en), 0);
    checkOutput("abort_flush_busy", 64'(busy), 1);
    waitIdle("abort_idle");
    checkOutput("abort_reads", 64'(rd_count - rd_base), 7);
    checkOutput("abort_dones", 64'(done_count - done_base), 0);
    checkOutput("abort_best_dir", 64'(best_dir), 0);
    checkOutput("abort_best_energy", best_energy, 192);

    // Asynchronous reset while draining, then a clean scan.
    applyStimulus(1'b0, 1'b0, 2'd0, 0);
    waitRead(0, 3, "drain_point");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkAllZero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    done_base = done_count;
    applyStimulus(1'b0, 1'b1, 2'd3, 768);
    waitIdle("rescan_idle");
    checkOutput("rescan_dones", 64'(done_count - done_base), 1);

    // Two results of 2^63 overflow the accumulator.
    sat_base = sat_done_count;
    sat_q.push_back(SAT_EXP);
    sat_start = 1'b1;
    @(negedge clk);
    sat_start = 1'b0;
    checkOutput("sat_busy_rise", 64'(sat_busy), 1);
    for (int n = 0; n < 100 && sat_busy; n++) @(negedge clk);
    checkOutput("sat_idle", 64'(sat_busy), 0);
    @(negedge clk);
    checkOutput("sat_dones", 64'(sat_done_count - sat_base), 1);

    checkOutput("exp_q_empty", 64'(exp_q.size()), 0);
    checkOutput("sat_q_empty", 64'(sat_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
